// File: rtl/sd_arb_pkg.sv
// Shared types for the SD request arbiter: FSM states, operation kinds,
// default requester count and a one-hot to index helper.
package sd_arb_pkg;

   localparam int NREQ_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } arb_op_e;

   // Highest set bit wins; callers only pass one-hot or zero vectors.
   function automatic int onehot_idx(input logic [31:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         r = v[i] ? i : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_owner,
// wrapping around, reported one-hot with a valid flag.
module rr_pick
   import sd_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT,
   parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last_owner,
   output logic [NREQ-1:0] pick,
   output logic            valid
);

   function automatic logic [LW-1:0] wrap_idx(input int x);
      return LW'((x >= NREQ) ? (x - NREQ) : x);
   endfunction

   // Scan from last_owner+1; only the first hit is recorded.
   always_comb begin
      pick  = '0;
      valid = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         pick[wrap_idx(int'(last_owner) + i)] = req[wrap_idx(int'(last_owner) + i)] & ~valid;
         valid = valid | req[wrap_idx(int'(last_owner) + i)];
      end
   end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates virtual-drive sector requests onto the shared hps_io SD port.
// Optional ISSUE-state ack timeout with req_err: define SD_ARB_TIMEOUT_EN.
module sd_req_arbiter
   import sd_arb_pkg::*;
#(
   parameter int NREQ           = NREQ_DEFAULT,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_rd,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ-1:0][31:0] req_lba,
   input  logic [NREQ-1:0]      img_mounted,
   input  logic [NREQ-1:0]      sd_ack,
   output logic [NREQ-1:0]      sd_rd,
   output logic [NREQ-1:0]      sd_wr,
   output logic [31:0]          sd_lba,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      req_done,
   output logic                 busy
`ifdef SD_ARB_TIMEOUT_EN
   ,
   output logic                 req_err
`endif
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e       state_r, state_nxt_s;
   arb_op_e          op_s;
   logic [NREQ-1:0]  pend_rd_r, pend_wr_r, pend_rd_nxt_s, pend_wr_nxt_s;
   logic [NREQ-1:0]  clr_rd_s, clr_wr_s;
   logic [NREQ-1:0]  ack_prev_r;
   logic [LW-1:0]    last_owner_r, last_owner_nxt_s;
   logic [NREQ-1:0]  sd_rd_r, sd_wr_r, sd_rd_nxt_s, sd_wr_nxt_s;
   logic [NREQ-1:0]  grant_r, grant_nxt_s, done_r, done_nxt_s;
   logic [31:0]      sd_lba_r, sd_lba_nxt_s;
   logic             busy_r, busy_nxt_s;
   logic [NREQ-1:0]  pick_s;
   logic             pick_valid_s;
   logic [LW-1:0]    pick_idx_s, owner_idx_s;
   logic             ack_rise_s, ack_fall_s;
`ifdef SD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]    to_cnt_r, to_cnt_nxt_s;
   logic             err_r, err_nxt_s;
`endif

   rr_pick #(.NREQ(NREQ), .LW(LW)) u_rr_pick (
      .req        (pend_rd_r | pend_wr_r),
      .last_owner (last_owner_r),
      .pick       (pick_s),
      .valid      (pick_valid_s)
   );

   assign pick_idx_s  = LW'(onehot_idx(32'(pick_s)));
   assign owner_idx_s = LW'(onehot_idx(32'(grant_r)));
   // Acks from drives that do not own the port are masked out here.
   assign ack_rise_s  = |(sd_ack & ~ack_prev_r & grant_r);
   assign ack_fall_s  = |(~sd_ack & ack_prev_r & grant_r);
   assign op_s        = (|(pend_wr_r & pick_s)) ? OP_WR : OP_RD;

   // Next-state and next-output decode for the transfer FSM.
   always_comb begin
      state_nxt_s      = state_r;
      sd_rd_nxt_s      = sd_rd_r;
      sd_wr_nxt_s      = sd_wr_r;
      grant_nxt_s      = grant_r;
      sd_lba_nxt_s     = sd_lba_r;
      last_owner_nxt_s = last_owner_r;
      done_nxt_s       = '0;
      clr_rd_s         = '0;
      clr_wr_s         = '0;
`ifdef SD_ARB_TIMEOUT_EN
      to_cnt_nxt_s     = '0;
      err_nxt_s        = 1'b0;
`endif
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s  = ISSUE;
               grant_nxt_s  = pick_s;
               sd_lba_nxt_s = req_lba[pick_idx_s];
               if (op_s == OP_WR) begin
                  sd_wr_nxt_s = pick_s;
                  clr_wr_s    = pick_s;
               end else begin
                  sd_rd_nxt_s = pick_s;
                  clr_rd_s    = pick_s;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (ack_rise_s) begin
               sd_rd_nxt_s = '0;
               sd_wr_nxt_s = '0;
               state_nxt_s = XFER;
            end
`ifdef SD_ARB_TIMEOUT_EN
            else if (to_cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
               sd_rd_nxt_s = '0;
               sd_wr_nxt_s = '0;
               done_nxt_s  = grant_r;
               err_nxt_s   = 1'b1;
               state_nxt_s = DONE;
            end
`endif
            else begin
               state_nxt_s = ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
               to_cnt_nxt_s = to_cnt_r + CW'(1);
`endif
            end
         end
         XFER: begin
            if (ack_fall_s) begin
               done_nxt_s  = grant_r;
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = XFER;
            end
         end
         DONE: begin
            grant_nxt_s      = '0;
            last_owner_nxt_s = owner_idx_s;
            state_nxt_s      = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
            sd_rd_nxt_s = '0;
            sd_wr_nxt_s = '0;
            grant_nxt_s = '0;
         end
      endcase
   end

   // A request pulse beats both the grant clear and a mount clear in the same cycle.
   always_comb begin
      pend_rd_nxt_s = (pend_rd_r & ~clr_rd_s & ~img_mounted) | req_rd;
      pend_wr_nxt_s = (pend_wr_r & ~clr_wr_s & ~img_mounted) | req_wr;
      busy_nxt_s    = (|(pend_rd_nxt_s | pend_wr_nxt_s)) | (state_nxt_s != IDLE);
   end

   // FSM state register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Pending bits, ack history and registered outputs.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pend_rd_r    <= '0;
         pend_wr_r    <= '0;
         ack_prev_r   <= '0;
         last_owner_r <= LW'(NREQ - 1);
         sd_rd_r      <= '0;
         sd_wr_r      <= '0;
         grant_r      <= '0;
         done_r       <= '0;
         sd_lba_r     <= 32'd0;
         busy_r       <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
         to_cnt_r     <= '0;
         err_r        <= 1'b0;
`endif
      end else begin
         pend_rd_r    <= pend_rd_nxt_s;
         pend_wr_r    <= pend_wr_nxt_s;
         ack_prev_r   <= sd_ack;
         last_owner_r <= last_owner_nxt_s;
         sd_rd_r      <= sd_rd_nxt_s;
         sd_wr_r      <= sd_wr_nxt_s;
         grant_r      <= grant_nxt_s;
         done_r       <= done_nxt_s;
         sd_lba_r     <= sd_lba_nxt_s;
         busy_r       <= busy_nxt_s;
`ifdef SD_ARB_TIMEOUT_EN
         to_cnt_r     <= to_cnt_nxt_s;
         err_r        <= err_nxt_s;
`endif
      end
   end

   assign sd_rd    = sd_rd_r;
   assign sd_wr    = sd_wr_r;
   assign sd_lba   = sd_lba_r;
   assign grant    = grant_r;
   assign req_done = done_r;
   assign busy     = busy_r;
`ifdef SD_ARB_TIMEOUT_EN
   assign req_err  = err_r;
`endif

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of virtual-drive requesters (0=HDD, 1=floppy 1, 2=floppy 2).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, clk_sys cycles allowed between sd_rd/sd_wr rise and sd_ack rise.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk_sys is the single clock, and reset is synchronous and active-high.
REQ-004 Port: clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: req_rd  in  NREQ  one-cycle read-request pulse per requester.
REQ-007 Port: req_wr  in  NREQ  one-cycle write-request pulse per requester.
REQ-008 Port: req_lba  in  NREQ x 32  sector address per requester, valid while its request is pending.
REQ-009 Port: img_mounted  in  NREQ  mount pulse per drive; clears that drive's pending requests.
REQ-010 Port: sd_ack  in  NREQ  per-drive acknowledge from hps_io.
REQ-011 Port: sd_rd  out  NREQ  per-drive read strobe, at most one bit set.
REQ-012 Port: sd_wr  out  NREQ  per-drive write strobe, at most one bit set.
REQ-013 Port: sd_lba  out  32  latched LBA of the granted request.
REQ-014 Port: grant  out  NREQ  one-hot owner of the current transfer; selects the sd_buff_din mux.
REQ-015 Port: req_done  out  NREQ  one-cycle completion pulse to the owner.
REQ-016 Port: busy  out  1  CPU wait: high while any request is pending or in flight.

Function
REQ-017 Each requester SHALL have separate pending_rd and pending_wr bits, set on the req pulse and cleared on grant of that operation.
REQ-018 Repeated pulses while a bit is pending SHALL merge into the single pending bit.
REQ-019 States SHALL be IDLE, ISSUE, XFER and DONE.
REQ-020 IDLE: if any bit is pending, the block SHALL pick the requester round-robin starting at last_owner+1, latch its LBA into sd_lba, set grant, and go to ISSUE.
REQ-021 Within one requester, write SHALL take priority over read; the read stays pending. sd_rd and sd_wr SHALL never be high together.
REQ-022 ISSUE: the granted sd_rd or sd_wr bit SHALL be high. On sd_ack rise for the owner, the strobe SHALL drop and the state SHALL go to XFER.
REQ-023 XFER: on sd_ack fall for the owner, the state SHALL go to DONE.
REQ-024 DONE: the block SHALL pulse req_done[owner] for one cycle, clear grant, update last_owner, and return to IDLE.
REQ-025 Latency from an idle arbiter: a request pulse at cycle N SHALL give the pending bit at N+1 and the strobe at N+2.
REQ-026 busy SHALL equal the OR of all pending bits, OR state not equal to IDLE.
REQ-027 A pulse that arrives in the same cycle as its own pending bit is cleared SHALL win, and the bit SHALL stay set.
REQ-028 img_mounted[i] SHALL clear pending_rd[i] and pending_wr[i]. A transfer already granted to drive i SHALL run to DONE normally.
REQ-029 sd_ack bits of non-owners SHALL be ignored.
REQ-030 After reset, last_owner SHALL be NREQ-1, so requester 0 wins the first arbitration.

Reset
REQ-031 On reset the block SHALL enter IDLE and clear all pending bits.
REQ-032 On reset sd_rd, sd_wr, grant, req_done and busy SHALL be 0, sd_lba SHALL be 0, and the timeout counter SHALL be 0.
REQ-033 Reset during ISSUE or XFER SHALL abort the transfer with no req_done pulse.

Configuration
REQ-034 Macro SD_ARB_TIMEOUT_EN.
REQ-035 With SD_ARB_TIMEOUT_EN defined, a counter SHALL run in ISSUE. On reaching TIMEOUT_CYCLES, the strobe SHALL drop and the state SHALL go to DONE. req_done SHALL pulse and output req_err (1 bit) SHALL pulse in the same cycle.
REQ-036 Without SD_ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely, and neither the counter nor req_err SHALL exist.

Structure
REQ-037 Package sd_arb_pkg SHALL hold the state enum (IDLE, ISSUE, XFER, DONE), the op enum (OP_RD, OP_WR) and the default NREQ constant.
REQ-038 Sub-module rr_pick SHALL be a combinational round-robin selector: inputs are the request vector and last_owner; outputs are the one-hot pick and a valid flag.

Verification
REQ-039 The bench SHALL cover: req_rd[0] pulse at cycle 10 -> sd_rd=001 at cycle 12; ack high 3 cycles -> req_done[0] pulse once, busy low afterwards.
REQ-040 The bench SHALL cover: req_wr[1] and req_rd[2] in the same cycle from reset -> drive 1 write served first, then drive 2 read; the grant sequence is 010, then 100.
REQ-041 The bench SHALL cover: req_rd[1] and req_wr[1] together -> sd_wr=010 first, then sd_rd=010; sd_rd and sd_wr are never both high.
REQ-042 The bench SHALL cover: img_mounted[2] while drive 2 is pending and drive 0 is in XFER -> drive 0 completes, drive 2 is never granted, busy falls.
REQ-043 The bench SHALL cover: reset asserted in XFER -> next cycle all outputs are 0 and no req_done pulse occurs.
REQ-044 The bench SHALL cover, with SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> strobe drops after 16 cycles and req_done plus req_err pulse together.
